arp_datagram_gen: RTL and testbench
===================================

Name: arp_datagram_gen

Overview:
- Parametrised successor of the byte-wide ARP payload builder.
- Emits a 28-byte ARP payload (HTYPE, PTYPE, HLEN, PLEN, OPER, SHA, SPA, THA, TPA) on a DATA_BYTES-wide AXI-Stream master with full tready backpressure.
- Triggered by an explicit start pulse or by the rising edge of s_axis_tuser.
- When disabled, passes the upstream stream through unchanged. Sits between the Ethernet MAC-header inserter and the upstream payload source.

Parameters:
- DATA_BYTES, 1: stream width in bytes; legal values 1, 2, 4.
- HW_TYPE, 16'h0001: HTYPE field value.
- PROTO_TYPE, 16'h0800: PTYPE field value.

Ports:
- s_axis_aclk  in  1  single clock.
- s_axis_areset  in  1  reset, asynchronous, active-high.
- arp_enable  in  1  1 = generator mode, 0 = passthrough; sampled only in IDLE.
- arp_start  in  1  one-cycle frame request.
- arp_opcode  in  16  OPER field.
- arp_srcMac  in  48  SHA field.
- arp_srcIP  in  32  SPA field.
- arp_destMac  in  48  THA field.
- arp_destIP  in  32  TPA field.
- busy  out  1  high from trigger until the last beat is accepted.
- s_axis_tdata  in  8*DATA_BYTES  upstream data.
- s_axis_tkeep  in  DATA_BYTES  upstream byte enables.
- s_axis_tlast / s_axis_tuser / s_axis_tvalid  in  1 each  upstream sideband.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata  out  8*DATA_BYTES  output data; lane 0 (bits [7:0]) is the earliest byte on the wire.
- m_axis_tkeep  out  DATA_BYTES  output byte enables.
- m_axis_tlast / m_axis_tuser / m_axis_tvalid  out  1 each  output sideband.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset values: state = IDLE, mode_q = 0, m_tvalid = 0, m_tlast = 0, m_tuser = 0, m_tkeep = 0, m_tdata = 0, busy = 0, idx = 0, tuser_q = 0.
- Mode select: mode_q <= arp_enable in IDLE only. All output muxes use mode_q, never raw arp_enable, so toggling arp_enable mid-frame cannot truncate a frame.
- mode_q = 0: m_axis_* = s_axis_* and s_axis_tready = m_axis_tready, all combinational.
- mode_q = 1, IDLE: s_axis_tready = 1 (upstream beats are discarded). m_tvalid = 0.
- Trigger condition, in IDLE with arp_enable = 1: arp_start = 1, or (s_axis_tuser = 1 and tuser_q = 0). tuser_q is a registered copy of s_axis_tuser.
  - Both sources in the same cycle produce exactly one frame.
  - Triggers while busy are ignored, not queued.
- On trigger:
  - Latch all five field inputs.
  - If arp_opcode == 16'h0001 (request), the latched THA is forced to 48'h0.
  - Go to SEND; idx = 0; busy = 1; s_axis_tready = 0 until return to IDLE.
  - First beat is valid the cycle after trigger (latency 1), with m_tuser = 1 on that beat only.
- SEND state:
  - A beat is accepted when m_tvalid & m_tready. On acceptance, idx += DATA_BYTES and the next beat is loaded in the same edge.
  - tdata, tkeep, tlast and tuser stay stable while m_tvalid & !m_tready.
  - No bubbles when tready is held high.
  - Beat byte k carries payload byte idx+k; multi-byte fields are big-endian (MSB first).
- Frame length LEN = 28 bytes, giving 28 / 14 / 7 beats for DATA_BYTES = 1 / 2 / 4.
- Last beat: m_tlast = 1. m_tkeep has its low (LEN - idx) bits set; all other beats have tkeep all ones.
- After the last beat is accepted: m_tvalid = 0, busy = 0, state = IDLE. The earliest next trigger is the following cycle.
- Asynchronous reset mid-frame: outputs return to reset values immediately. The partial frame is abandoned; no tlast is emitted.
- Unused byte lanes on the last beat drive 8'h00.

Optional Feature:
- Macro: ARP_PAD_EN.
- Defined: LEN = 46. Bytes 28..45 are 8'h00 (minimum Ethernet payload). With DATA_BYTES = 4 this is 12 beats, and the last beat has tkeep = 4'b0011.
- Undefined: LEN = 28 and no pad logic is built.

Decomposition:
- Package arp_pkg holds ARP_OP_REQUEST = 16'h0001, ARP_OP_REPLY = 16'h0002, ARP_HLEN = 8'd6, ARP_PLEN = 8'd4, ARP_LEN = 28, ETH_MIN_PAYLOAD = 46, and the state enum {IDLE, SEND}.
- One combinational sub-module, arp_byte_sel: maps a byte index and the latched fields to one payload byte. It is instantiated DATA_BYTES times, at offsets idx+k.

Test Plan:
- DATA_BYTES = 1, tready = 1, arp_start with opcode = 2, srcMac = 00:0A:35:01:02:03, srcIP = C0A80102, destMac = 11:22:33:44:55:66, destIP = C0A80103 -> 28 consecutive beats 00 01 08 00 06 04 00 02 00 0A 35 … C0 A8 01 03; tuser on beat 0, tlast on beat 27.
- DATA_BYTES = 4, opcode = 1, destMac = FF..FF -> 7 beats; beat 0 tdata = 32'h00080100; bytes 18..23 are 00; last beat tkeep = 4'hF.
- Random tready (50%) -> payload bytes identical to the tready = 1 run; no tdata change while valid & !ready; busy falls the cycle after the last accept.
- arp_enable = 0 -> m_axis mirrors s_axis cycle-for-cycle, including tready. Toggling arp_enable mid-frame -> frame still completes with 28 bytes.
- arp_start and tuser rising edge in the same cycle, plus a second start during SEND -> exactly one frame. Assert reset at beat 10 -> m_tvalid = 0 immediately; next start gives a full frame.
- ARP_PAD_EN defined, DATA_BYTES = 2 -> 23 beats; bytes 28..45 are 00; tlast on beat 22 with tkeep = 2'b11.

Source files
------------

// File: rtl/arp_pkg.sv
// ARP payload generator: shared constants, state encoding and latched-field record.
package arp_pkg;

    localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam int unsigned ARP_LEN         = 28;
    localparam int unsigned ETH_MIN_PAYLOAD = 46;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Field order matches wire order after the fixed HTYPE/PTYPE/HLEN/PLEN header.
    typedef struct packed {
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

endpackage

// File: rtl/arp_byte_sel.sv
// Maps a payload byte index to the corresponding ARP payload byte (big-endian fields).
// Indices at or beyond the 28-byte ARP body return 8'h00, which also covers pad bytes.
module arp_byte_sel
    import arp_pkg::*;
#(
    parameter logic [15:0] HW_TYPE    = 16'h0001,
    parameter logic [15:0] PROTO_TYPE = 16'h0800
) (
    input  logic [5:0]  byte_idx,
    input  arp_fields_t fields,
    output logic [7:0]  byte_out
);

    logic [ARP_LEN*8-1:0] payload;
    int unsigned          pos;

    // Flatten the payload MSB-first and pick the requested byte.
    always_comb begin
        payload  = {HW_TYPE, PROTO_TYPE, ARP_HLEN, ARP_PLEN, fields};
        pos      = 0;
        byte_out = '0;
        if (byte_idx < 6'(ARP_LEN)) begin
            pos      = ARP_LEN - 1 - 32'(byte_idx);
            byte_out = payload[pos*8 +: 8];
        end
    end

endmodule

// File: rtl/arp_datagram_gen.sv
// ARP payload generator on a DATA_BYTES-wide AXI-Stream master, with passthrough mode.
// Optional feature macro ARP_PAD_EN: pads the frame with zeros to the 46-byte Ethernet minimum.
module arp_datagram_gen
    import arp_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 1,
    parameter logic [15:0] HW_TYPE    = 16'h0001,
    parameter logic [15:0] PROTO_TYPE = 16'h0800
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    input  logic                    arp_enable,
    input  logic                    arp_start,
    input  logic [15:0]             arp_opcode,
    input  logic [47:0]             arp_srcMac,
    input  logic [31:0]             arp_srcIP,
    input  logic [47:0]             arp_destMac,
    input  logic [31:0]             arp_destIP,
    output logic                    busy,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

`ifdef ARP_PAD_EN
    localparam int unsigned LEN = ETH_MIN_PAYLOAD;
`else
    localparam int unsigned LEN = ARP_LEN;
`endif
    localparam logic [6:0] LEN7 = 7'(LEN);
    localparam logic [6:0] DB7  = 7'(DATA_BYTES);

    state_t                  state_q, state_d;
    logic                    mode_q, tuser_q;
    logic [5:0]              idx_q, idx_d;
    arp_fields_t             fields_q, fields_d;
    logic                    load, finish, user_d, last_d;
    logic [6:0]              idx_ext, remain;
    logic [DATA_BYTES-1:0]   keep_d;
    logic [8*DATA_BYTES-1:0] beat_d;
    logic [8*DATA_BYTES-1:0] m_tdata_q;
    logic [DATA_BYTES-1:0]   m_tkeep_q;
    logic                    m_tvalid_q, m_tlast_q, m_tuser_q;
    logic                    trigger, accept;

    assign trigger = (state_q == IDLE) && arp_enable &&
                     (arp_start || (s_axis_tuser && !tuser_q));
    assign accept  = m_tvalid_q && m_axis_tready;
    assign busy    = (state_q == SEND);

    // The next beat is built from the post-edge index/fields so that a beat is
    // registered on the same edge that accepts the previous one (no bubbles).
    for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
        logic [5:0] lane_idx;
        assign lane_idx = idx_d + 6'(k);
        arp_byte_sel #(
            .HW_TYPE   (HW_TYPE),
            .PROTO_TYPE(PROTO_TYPE)
        ) u_byte_sel (
            .byte_idx(lane_idx),
            .fields  (fields_d),
            .byte_out(beat_d[8*k +: 8])
        );
    end

    // State, mode, field latch and output beat registers.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            tuser_q    <= 1'b0;
            idx_q      <= '0;
            fields_q   <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fields_q <= fields_d;
            tuser_q  <= s_axis_tuser;
            if (state_q == IDLE) begin
                mode_q <= arp_enable;
            end
            if (load) begin
                m_tdata_q  <= beat_d;
                m_tkeep_q  <= keep_d;
                m_tlast_q  <= last_d;
                m_tuser_q  <= user_d;
                m_tvalid_q <= 1'b1;
            end else if (finish) begin
                m_tdata_q  <= '0;
                m_tkeep_q  <= '0;
                m_tlast_q  <= 1'b0;
                m_tuser_q  <= 1'b0;
                m_tvalid_q <= 1'b0;
            end
        end
    end

    // Next-state, field capture and next-beat geometry (tlast / tkeep).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fields_d = fields_q;
        load     = 1'b0;
        finish   = 1'b0;
        user_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d       = SEND;
                    idx_d         = '0;
                    load          = 1'b1;
                    user_d        = 1'b1;
                    fields_d.oper = arp_opcode;
                    fields_d.sha  = arp_srcMac;
                    fields_d.spa  = arp_srcIP;
                    fields_d.tha  = (arp_opcode == ARP_OP_REQUEST) ? '0 : arp_destMac;
                    fields_d.tpa  = arp_destIP;
                end
            end
            SEND: begin
                if (accept) begin
                    if (m_tlast_q) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'(DATA_BYTES);
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        idx_ext = {1'b0, idx_d};
        remain  = LEN7 - idx_ext;
        last_d  = (idx_ext + DB7) >= LEN7;
        keep_d  = '1;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            keep_d[k] = !last_d || (7'(k) < remain);
        end
    end

    // Output mux: registered generator beats or combinational passthrough.
    always_comb begin
        if (mode_q) begin
            m_axis_tdata  = m_tdata_q;
            m_axis_tkeep  = m_tkeep_q;
            m_axis_tlast  = m_tlast_q;
            m_axis_tuser  = m_tuser_q;
            m_axis_tvalid = m_tvalid_q;
            s_axis_tready = (state_q == IDLE);
        end else begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tkeep  = s_axis_tkeep;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
        end
    end

endmodule

// File: tb/tb_arp_datagram_gen.sv
// Directed bench for arp_datagram_gen: one 1-byte and one 4-byte instance on shared stimulus.
module tb_arp_datagram_gen;

`ifdef ARP_PAD_EN
    localparam int LEN = 46;
`else
    localparam int LEN = 28;
`endif
    localparam logic [223:0] EXP_REPLY =
        224'h0001_0800_0604_0002_000A35010203_C0A80102_112233445566_C0A80103;
    localparam logic [223:0] EXP_REQ =
        224'h0001_0800_0604_0001_000A35010203_C0A80102_000000000000_C0A80103;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_enable, arp_start;
    logic [15:0] op;
    logic [47:0] smac, dmac;
    logic [31:0] sip, dip;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast, s_tuser, s_tvalid, tready;

    logic [7:0]  m1_tdata;
    logic [0:0]  m1_tkeep;
    logic        m1_tlast, m1_tuser, m1_tvalid, s1_tready, busy1;
    logic [31:0] m4_tdata;
    logic [3:0]  m4_tkeep;
    logic        m4_tlast, m4_tuser, m4_tvalid, s4_tready, busy4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_en;

    logic [31:0] md[2];
    logic [3:0]  mk[2];
    logic        mv[2], ml[2], mu[2], mb[2];
    logic [7:0]  got[2][64];
    int          nb[2], beats[2], frames[2], first_cyc[2], last_cyc[2];
    logic [3:0]  lastkeep[2];
    logic        hold[2], pend[2], hl[2];
    logic [31:0] hd[2];
    logic [3:0]  hk[2];
    logic [8*46-1:0] expv;

    always #5 clk = ~clk;

    arp_datagram_gen #(.DATA_BYTES(1)) u_dut1 (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .arp_enable(arp_enable), .arp_start(arp_start), .arp_opcode(op),
        .arp_srcMac(smac), .arp_srcIP(sip), .arp_destMac(dmac), .arp_destIP(dip),
        .busy(busy1),
        .s_axis_tdata(s_tdata[7:0]), .s_axis_tkeep(s_tkeep[0:0]), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tlast(m1_tlast),
        .m_axis_tuser(m1_tuser), .m_axis_tvalid(m1_tvalid), .m_axis_tready(tready)
    );

    arp_datagram_gen #(.DATA_BYTES(4)) u_dut4 (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .arp_enable(arp_enable), .arp_start(arp_start), .arp_opcode(op),
        .arp_srcMac(smac), .arp_srcIP(sip), .arp_destMac(dmac), .arp_destIP(dip),
        .busy(busy4),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s4_tready),
        .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep), .m_axis_tlast(m4_tlast),
        .m_axis_tuser(m4_tuser), .m_axis_tvalid(m4_tvalid), .m_axis_tready(tready)
    );

    assign md[0] = {24'h0, m1_tdata};
    assign md[1] = m4_tdata;
    assign mk[0] = {3'b0, m1_tkeep};
    assign mk[1] = m4_tkeep;
    assign mv[0] = m1_tvalid;
    assign mv[1] = m4_tvalid;
    assign ml[0] = m1_tlast;
    assign ml[1] = m4_tlast;
    assign mu[0] = m1_tuser;
    assign mu[1] = m4_tuser;
    assign mb[0] = busy1;
    assign mb[1] = busy4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: collects accepted bytes and checks per-beat protocol rules.
    always @(posedge clk) begin
        cyc++;
        if (rst || !mon_en) begin
            for (int d = 0; d < 2; d++) begin
                hold[d] = 1'b0;
                pend[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) begin
                    chk($sformatf("busy_fall_d%0d", d), mb[d], 1'b0);
                    chk($sformatf("valid_fall_d%0d", d), mv[d], 1'b0);
                    pend[d] = 1'b0;
                end
                if (hold[d]) begin
                    chk($sformatf("stall_valid_d%0d", d), mv[d], 1'b1);
                    chk($sformatf("stall_data_d%0d", d), md[d], hd[d]);
                    chk($sformatf("stall_keep_d%0d", d), mk[d], hk[d]);
                    chk($sformatf("stall_last_d%0d", d), ml[d], hl[d]);
                end
                hold[d] = mv[d] && !tready;
                hd[d]   = md[d];
                hk[d]   = mk[d];
                hl[d]   = ml[d];
                if (mv[d] && tready) begin
                    chk($sformatf("busy_beat_d%0d", d), mb[d], 1'b1);
                    chk($sformatf("tuser_beat%0d_d%0d", beats[d], d), mu[d], beats[d] == 0);
                    if (beats[d] == 0) first_cyc[d] = cyc;
                    last_cyc[d] = cyc;
                    for (int k = 0; k < (d == 1 ? 4 : 1); k++) begin
                        if (mk[d][k] && nb[d] < 64) begin
                            got[d][nb[d]] = md[d][8*k +: 8];
                            nb[d]++;
                        end
                    end
                    if (ml[d]) begin
                        lastkeep[d] = mk[d];
                        frames[d]++;
                        pend[d] = 1'b1;
                    end else begin
                        chk($sformatf("keep_full_d%0d", d), mk[d], (d == 1) ? 4'hF : 4'h1);
                    end
                    beats[d]++;
                end
            end
        end
    end

    task automatic clear_cap();
        for (int d = 0; d < 2; d++) begin
            nb[d]    = 0;
            beats[d] = 0;
        end
    endtask

    task automatic wait_frames(input string tag, input int target, input int limit, input bit rnd);
        int c = 0;
        while ((frames[0] < target || frames[1] < target) && c < limit) begin
            @(negedge clk);
            if (rnd) tready = 1'($urandom_range(0, 1));
            c++;
        end
        tready = 1'b1;
        chk({tag, "_done"}, (frames[0] >= target) && (frames[1] >= target), 1'b1);
    endtask

    task automatic chk_frame(input string tag, input logic [223:0] body, input bit nobubble);
        logic [7:0] e;
        expv = {body, 144'h0};
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_len_d%0d", tag, d), nb[d], LEN);
            chk($sformatf("%s_beats_d%0d", tag, d), beats[d], (d == 1) ? (LEN + 3) / 4 : LEN);
            for (int i = 0; i < LEN; i++) begin
                e = expv[8*(45-i) +: 8];
                chk($sformatf("%s_byte%0d_d%0d", tag, i, d), got[d][i], e);
            end
            if (nobubble)
                chk($sformatf("%s_nobubble_d%0d", tag, d), last_cyc[d] - first_cyc[d], beats[d] - 1);
        end
        chk({tag, "_lastkeep_d1"}, lastkeep[1], (LEN % 4 == 0) ? 4'hF : 4'((1 << (LEN % 4)) - 1));
    endtask

    initial begin
        int f0;
        for (int d = 0; d < 2; d++) begin
            frames[d] = 0; lastkeep[d] = '0; first_cyc[d] = 0; last_cyc[d] = 0;
        end
        clear_cap();
        mon_en = 1'b1;
        rst = 1'b1; arp_enable = 1'b0; arp_start = 1'b0;
        op = 16'h0002; smac = 48'h000A35010203; sip = 32'hC0A80102;
        dmac = 48'h112233445566; dip = 32'hC0A80103;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;
        tready = 1'b1;

        // Reset state, then generator-mode idle.
        repeat (3) @(negedge clk);
        chk("rst_valid_d1", m1_tvalid, 1'b0);
        chk("rst_busy_d1", busy1, 1'b0);
        chk("rst_busy_d4", busy4, 1'b0);
        rst = 1'b0;
        arp_enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid_d4", m4_tvalid, 1'b0);
        chk("idle_tdata_d4", m4_tdata, 32'h0);
        chk("idle_tkeep_d4", m4_tkeep, 4'h0);
        chk("idle_sready_d1", s1_tready, 1'b1);

        // Reply frame via arp_start, tready held high.
        arp_start = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        chk("lat_valid_d1", m1_tvalid, 1'b1);
        chk("lat_tuser_d1", m1_tuser, 1'b1);
        chk("lat_tdata_d1", m1_tdata, 8'h00);
        chk("lat_tdata_d4", m4_tdata, 32'h00080100);
        chk("lat_busy_d4", busy4, 1'b1);
        chk("lat_sready_d1", s1_tready, 1'b0);
        wait_frames("reply", 1, 100, 1'b0);
        chk_frame("reply", EXP_REPLY, 1'b1);

        // Request frame: start and tuser rise together, second start mid-frame ignored.
        @(negedge clk);
        clear_cap();
        op = 16'h0001; dmac = 48'hFFFFFFFFFFFF;
        arp_start = 1'b1; s_tuser = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        repeat (2) @(negedge clk);
        arp_start = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        wait_frames("request", 2, 100, 1'b0);
        repeat (60) @(negedge clk);
        chk("one_frame_d1", frames[0], 2);
        chk("one_frame_d4", frames[1], 2);
        chk_frame("request", EXP_REQ, 1'b1);
        s_tuser = 1'b0;

        // Random backpressure, arp_enable dropped mid-frame.
        @(negedge clk);
        clear_cap();
        op = 16'h0002; dmac = 48'h112233445566;
        arp_start = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        arp_enable = 1'b0;
        wait_frames("rnd", 3, 2000, 1'b1);
        chk_frame("rnd", EXP_REPLY, 1'b0);

        // Passthrough: outputs follow inputs combinationally.
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        for (int v = 0; v < 4; v++) begin
            s_tdata  = 32'hA5C3_0F01 + 32'(v) * 32'h1111_2222;
            s_tkeep  = 4'(4'h9 + v);
            s_tlast  = v[0];
            s_tuser  = v[1];
            s_tvalid = ~v[0];
            tready   = v[0] ^ v[1];
            #1;
            chk($sformatf("pt%0d_tdata_d1", v), m1_tdata, s_tdata[7:0]);
            chk($sformatf("pt%0d_tdata_d4", v), m4_tdata, s_tdata);
            chk($sformatf("pt%0d_tkeep_d4", v), m4_tkeep, s_tkeep);
            chk($sformatf("pt%0d_side_d4", v), {m4_tlast, m4_tuser, m4_tvalid}, {s_tlast, s_tuser, s_tvalid});
            chk($sformatf("pt%0d_sready_d1", v), s1_tready, tready);
            chk($sformatf("pt%0d_sready_d4", v), s4_tready, tready);
            chk($sformatf("pt%0d_busy_d1", v), busy1, 1'b0);
            @(negedge clk);
        end
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;
        tready = 1'b1;

        // Reset asserted at beat 10 abandons the frame; next start is complete.
        arp_enable = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        clear_cap();
        f0 = frames[0];
        arp_start = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        for (int c = 0; c < 40 && beats[0] < 10; c++) @(negedge clk);
        chk("beat10_reached", beats[0], 10);
        rst = 1'b1;
        #1;
        chk("arst_valid_d1", m1_tvalid, 1'b0);
        chk("arst_valid_d4", m4_tvalid, 1'b0);
        chk("arst_busy_d1", busy1, 1'b0);
        chk("arst_no_tlast_d1", frames[0], f0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_cap();
        arp_start = 1'b1;
        @(negedge clk);
        arp_start = 1'b0;
        wait_frames("post_rst", f0 + 1, 100, 1'b0);
        chk_frame("post_rst", EXP_REPLY, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
